// File: rtl/fpu_pkg.sv
// Shared FPU request types, field widths and status encodings.
// No ports: the request struct, the one-hot status constants and a one-hot checker.
package fpu_pkg;

  localparam int unsigned SIGN_W   = 1;
  localparam int unsigned EXP_W    = 7;
  localparam int unsigned MANT_W   = 24;
  localparam int unsigned WORD_W   = SIGN_W + EXP_W + MANT_W;
  localparam int unsigned OP_W     = 2;
  localparam int unsigned STATUS_W = 4;

  localparam logic [STATUS_W-1:0] ST_EXACT     = 4'b0001;
  localparam logic [STATUS_W-1:0] ST_INEXACT   = 4'b0010;
  localparam logic [STATUS_W-1:0] ST_OVERFLOW  = 4'b0100;
  localparam logic [STATUS_W-1:0] ST_UNDERFLOW = 4'b1000;

  // 66-bit operand request as queued in the FIFO
  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [OP_W-1:0]   op;
  } fpu_req_t;

  // True only for one of the four legal status codes (0000 is illegal)
  function automatic logic is_onehot(input logic [STATUS_W-1:0] s);
    case (s)
      ST_EXACT, ST_INEXACT, ST_OVERFLOW, ST_UNDERFLOW: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// Request FIFO for the FPU sequencer; pointers wrap modulo DEPTH (power of two).
// Ports: clk, reset (async, active-low); i_push/i_data write side; i_pop/o_data
// read side (o_data shows the head); o_count fill level; o_full/o_empty from the
// registered count only.
module fpu_req_fifo
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = fpu_req_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  T                       i_data,
  input  logic                   i_pop,
  output T                       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Full/empty come from the registered count, so a pop never frees a slot in the same cycle
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage needs no reset: stale entries are unreachable once the pointers clear
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: rtl/fpu_sequencer.sv
// Queues operand requests, presents each to the FPU core for HOLD_CYCLES, then
// captures and emits the result with a valid/ready handshake.
// Ports: clk, reset (async, active-low); in_valid/in_ready/in_a/in_b/in_op request
// side; fpu_a/fpu_b/fpu_op to the core, fpu_data/fpu_status from it;
// out_valid/out_ready/out_data/out_status result side; occupancy FIFO fill;
// status_err sticky flag for a non-one-hot captured status.
module fpu_sequencer
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_W-1:0]      in_a,
  input  logic [WORD_W-1:0]      in_b,
  input  logic [OP_W-1:0]        in_op,
  output logic [WORD_W-1:0]      fpu_a,
  output logic [WORD_W-1:0]      fpu_b,
  output logic [OP_W-1:0]        fpu_op,
  input  logic [WORD_W-1:0]      fpu_data,
  input  logic [STATUS_W-1:0]    fpu_status,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_W-1:0]      out_data,
  output logic [STATUS_W-1:0]    out_status,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   status_err
);

  localparam int unsigned CTR_W = $clog2(HOLD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_EMIT
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CTR_W-1:0]     r_ctr;
  logic [WORD_W-1:0]    r_fpu_a;
  logic [WORD_W-1:0]    r_fpu_b;
  logic [OP_W-1:0]      r_fpu_op;
  logic                 r_out_valid;
  logic [WORD_W-1:0]    r_out_data;
  logic [STATUS_W-1:0]  r_out_status;
  logic                 r_status_err;
  fpu_req_t             w_push_req;
  fpu_req_t             w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_ctr_dec;
  logic                 w_capture;
  logic                 w_release;

  assign w_push_req = '{a: in_a, b: in_b, op: in_op};
  assign in_ready   = !w_full;

  fpu_req_fifo #(
    .DEPTH (DEPTH),
    .T     (fpu_req_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (in_valid && in_ready),
    .i_data  (w_push_req),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (occupancy),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; EMIT goes straight back to HOLD when work is queued
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_HOLD;
      S_HOLD:  if (r_ctr == '0) w_next = S_EMIT;
      S_EMIT:  if (out_ready) w_next = w_empty ? S_IDLE : S_HOLD;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath control strobes
  always_comb begin
    w_pop     = 1'b0;
    w_ctr_dec = 1'b0;
    w_capture = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_IDLE: w_pop = !w_empty;
      S_HOLD: begin
        w_capture = (r_ctr == '0);
        w_ctr_dec = (r_ctr != '0);
      end
      S_EMIT: begin
        w_release = out_ready;
        w_pop     = out_ready && !w_empty;
      end
      default: ;
    endcase
  end

  // Operand hold registers, hold counter and result capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctr        <= '0;
      r_fpu_a      <= '0;
      r_fpu_b      <= '0;
      r_fpu_op     <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_status <= '0;
      r_status_err <= 1'b0;
    end else begin
      if (w_pop) begin
        r_fpu_a  <= w_head.a;
        r_fpu_b  <= w_head.b;
        r_fpu_op <= w_head.op;
        r_ctr    <= CTR_W'(HOLD_CYCLES - 1);
      end else if (w_ctr_dec) begin
        r_ctr <= r_ctr - CTR_W'(1);
      end
      if (w_capture) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= fpu_data;
        r_out_status <= fpu_status;
        if (!is_onehot(fpu_status)) r_status_err <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign fpu_a      = r_fpu_a;
  assign fpu_b      = r_fpu_b;
  assign fpu_op     = r_fpu_op;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_status = r_out_status;
  assign status_err = r_status_err;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Self-checking bench for fpu_sequencer with a simple combinational FPU core model.
module tb_fpu_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_data;
  logic [3:0]  fpu_status;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_status;
  logic [$clog2(DEPTH):0] occupancy;
  logic        status_err;

  logic        ovr_en;
  logic [3:0]  ovr_status;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp_data;
    logic [3:0]  exp_status;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  fpu_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_op     (fpu_op),
    .fpu_data   (fpu_data),
    .fpu_status (fpu_status),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_status (out_status),
    .occupancy  (occupancy),
    .status_err (status_err)
  );

  function automatic logic [31:0] model_data(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F00_0000 && b == 32'h3F00_0000) return 32'h4000_0000;
    return a ^ b;
  endfunction

  // FPU core model: XOR data, status one-hot selected by op unless overridden
  always_comb begin
    fpu_data   = model_data(fpu_a, fpu_b);
    fpu_status = ovr_en ? ovr_status : (4'b0001 << fpu_op);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      output logic acc);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    acc      = in_ready;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 400) begin
      step();
      n++;
    end
  endtask

  initial begin
    logic        acc;
    int          n;
    logic [31:0] pa [6];
    logic [31:0] pb [6];
    logic [1:0]  pop_op [6];
    logic [31:0] snap_a;
    logic        seen;

    vecs[0] = '{32'h3F00_0000, 32'h3F00_0000, 2'd0, 32'h4000_0000, 4'b0001};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 2'd1, 32'hFFFF_FFFF, 4'b0010};
    vecs[2] = '{32'h8000_0000, 32'h00FF_FFFF, 2'd2, 32'h80FF_FFFF, 4'b0100};
    vecs[3] = '{32'h1234_5678, 32'h0000_FFFF, 2'd3, 32'h1234_A987, 4'b1000};

    reset      = 1'b1;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    in_op      = '0;
    out_ready  = 1'b1;
    ovr_en     = 1'b0;
    ovr_status = '0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fpu_a", fpu_a, 32'd0);
    check("rst_out_status", 32'(out_status), 32'd0);
    check("rst_status_err", 32'(status_err), 32'd0);

    // Table: single ops into an idle block, first one on the first edge after reset
    foreach (vecs[i]) begin
      push(vecs[i].a, vecs[i].b, vecs[i].op, acc);
      check("vec_accept", 32'(acc), 32'd1);
      wait_valid(n);
      check("vec_latency", 32'(n), 32'(HOLD + 1));
      check("vec_data", out_data, vecs[i].exp_data);
      check("vec_status", 32'(out_status), 32'(vecs[i].exp_status));
      check("vec_fpu_a", fpu_a, vecs[i].a);
      check("vec_fpu_b", fpu_b, vecs[i].b);
      check("vec_fpu_op", 32'(fpu_op), 32'(vecs[i].op));
      step();
      check("vec_release", 32'(out_valid), 32'd0);
    end
    check("vec_status_err", 32'(status_err), 32'd0);

    // Backpressure in EMIT while filling the FIFO
    out_ready = 1'b0;
    push(32'h1111_1111, 32'h2222_2222, 2'd0, acc);
    wait_valid(n);
    check("bp_latency", 32'(n), 32'(HOLD + 1));
    check("bp_data", out_data, 32'h3333_3333);
    for (int i = 0; i < 5; i++) begin
      pa[i]     = {24'hB0_0000, 8'(i)};
      pb[i]     = {16'h0000, 8'(i + 1), 8'h00};
      pop_op[i] = 2'(i);
      push(pa[i], pb[i], pop_op[i], acc);
      check("fill_accept", 32'(acc), (i < 4) ? 32'd1 : 32'd0);
      check("bp_hold_data", out_data, 32'h3333_3333);
      check("bp_hold_fpu_a", fpu_a, 32'h1111_1111);
    end
    check("fill_occupancy", 32'(occupancy), 32'd4);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 95; i++) begin
      step();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", out_data, 32'h3333_3333);
      check("bp_hold_status", 32'(out_status), 32'b0001);
      check("bp_hold_fpu_a", fpu_a, 32'h1111_1111);
    end
    out_ready = 1'b1;
    step();
    check("fill_first_pop_occ", 32'(occupancy), 32'd3);
    for (int i = 0; i < 4; i++) begin
      wait_valid(n);
      check("fill_b2b_gap", 32'(n), 32'(HOLD));
      check("fill_order_data", out_data, model_data(pa[i], pb[i]));
      check("fill_order_status", 32'(out_status), 32'(4'b0001 << pop_op[i]));
      step();
    end
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check("fill_refused_absent", 32'(seen), 32'd0);

    // Simultaneous push and pop at occupancy 2
    out_ready = 1'b0;
    pa[0] = 32'hA000_0000; pb[0] = 32'h0000_000A; pop_op[0] = 2'd0;
    pa[1] = 32'h0C00_0000; pb[1] = 32'h0000_0C00; pop_op[1] = 2'd1;
    pa[2] = 32'h00D0_0000; pb[2] = 32'h0000_D000; pop_op[2] = 2'd2;
    pa[3] = 32'h000E_0000; pb[3] = 32'h0000_00E0; pop_op[3] = 2'd3;
    push(pa[0], pb[0], pop_op[0], acc);
    wait_valid(n);
    check("sim_first_data", out_data, 32'hA000_000A);
    push(pa[1], pb[1], pop_op[1], acc);
    push(pa[2], pb[2], pop_op[2], acc);
    check("sim_occ_before", 32'(occupancy), 32'd2);
    in_valid  = 1'b1;
    in_a      = pa[3];
    in_b      = pb[3];
    in_op     = pop_op[3];
    out_ready = 1'b1;
    check("sim_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("sim_occ_after", 32'(occupancy), 32'd2);
    for (int i = 1; i < 4; i++) begin
      wait_valid(n);
      check("sim_gap", 32'(n), 32'(HOLD));
      check("sim_order_data", out_data, model_data(pa[i], pb[i]));
      step();
    end

    // Illegal status sets the sticky error
    ovr_en     = 1'b1;
    ovr_status = 4'b0110;
    push(32'h0101_0101, 32'h1010_1010, 2'd0, acc);
    wait_valid(n);
    check("err_status", 32'(out_status), 32'b0110);
    check("err_flag_set", 32'(status_err), 32'd1);
    step();
    ovr_en = 1'b0;
    push(32'h0202_0202, 32'h2020_2020, 2'd1, acc);
    wait_valid(n);
    check("err_next_status", 32'(out_status), 32'b0010);
    check("err_flag_sticky", 32'(status_err), 32'd1);
    step();

    // Reset in the middle of HOLD with two entries queued
    push(32'h0303_0303, 32'h3030_3030, 2'd0, acc);
    push(32'h0404_0404, 32'h4040_4040, 2'd1, acc);
    push(32'h0505_0505, 32'h5050_5050, 2'd2, acc);
    check("mid_occ_before", 32'(occupancy), 32'd2);
    repeat (10) step();
    #2 reset = 1'b0;
    #1;
    check("mid_in_ready", 32'(in_ready), 32'd1);
    check("mid_occupancy", 32'(occupancy), 32'd0);
    check("mid_fpu_a", fpu_a, 32'd0);
    check("mid_fpu_b", fpu_b, 32'd0);
    check("mid_fpu_op", 32'(fpu_op), 32'd0);
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_out_data", out_data, 32'd0);
    check("mid_out_status", 32'(out_status), 32'd0);
    check("mid_status_err", 32'(status_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen   = 1'b0;
    snap_a = fpu_a;
    for (int i = 0; i < 200; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check("mid_no_valid", 32'(seen), 32'd0);
    check("mid_fpu_a_idle", fpu_a, snap_a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
